// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions used by the packet FIFO slice.
//   AXIS_DATA_W  default tdata width
//   axis_beat_t  one stored beat, {tlast, tdata}
//   sf_state_e   store-and-forward release state
//   clog2        constant log2 (ceiling) for deriving address widths
package axis_pkg;

    localparam int unsigned AXIS_DATA_W = 32;

    typedef struct packed {
        logic                   tlast;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_beat_t;

    typedef enum logic {
        ST_IDLE,
        ST_XFER
    } sf_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage for the packet FIFO.
//   clk      write clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  word to store
//   rd_addr  read address
//   rd_data  word at rd_addr, asynchronous read
// Contents are deliberately not reset.
module axis_fifo_mem
    import axis_pkg::*;
#(
    parameter  int unsigned WIDTH  = AXIS_DATA_W + 1,
    parameter  int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo.sv
// First-word-fall-through AXI-Stream FIFO that preserves tlast boundaries.
//   clk, reset          single clock, asynchronous active-high reset
//   s_axis_*            upstream slave side (tdata/tvalid/tready/tlast)
//   m_axis_*            downstream master side (tdata/tvalid/tready/tlast)
//   fill_level          stored beats, 0..DEPTH
//   pkt_count           stored tlast beats (complete packets)
// Build option AXIS_PKT_FIFO_STORE_FWD_EN: when defined, the head is only
// released once a whole packet is stored (or the FIFO is full); otherwise
// the FIFO is cut-through.
module axis_pkt_fifo
    import axis_pkg::*;
#(
    parameter  int unsigned DATA_W = AXIS_DATA_W,
    parameter  int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic [ADDR_W:0]   fill_level,
    output logic [ADDR_W:0]   pkt_count
);

    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] fill_q,   fill_d;
    logic [ADDR_W:0] pkt_q,    pkt_d;
    logic            rdy_en_q;

    logic            empty, full, push, pop, head_last;
    logic [DATA_W:0] rd_word;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // tready is held low during reset and for the rest of that cycle; a
    // full FIFO refuses a push even when a pop happens on the same edge.
    assign s_axis_tready = rdy_en_q && !full;
    assign push          = s_axis_tvalid && s_axis_tready;
    assign pop           = m_axis_tvalid && m_axis_tready;

    axis_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr_q[ADDR_W-1:0]),
        .rd_data (rd_word)
    );

    assign m_axis_tdata = rd_word[DATA_W-1:0];
    assign head_last    = rd_word[DATA_W];
    assign m_axis_tlast = head_last;
    assign fill_level   = fill_q;
    assign pkt_count    = pkt_q;

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    sf_state_e state_q, state_d;

    // ST_XFER latches "head of a packet has been offered" so valid cannot
    // be withdrawn mid-packet when pkt_count or full drop during the drain.
    assign m_axis_tvalid = !empty &&
                           ((state_q == ST_XFER) || (pkt_q != '0) || full);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (m_axis_tvalid && !(pop && head_last)) state_d = ST_XFER;
            ST_XFER: if (pop && head_last)                     state_d = ST_IDLE;
            default:                                           state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end
`else
    assign m_axis_tvalid = !empty;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        pkt_d    = pkt_q;
        if (push) wr_ptr_d = wr_ptr_q + ONE;
        if (pop)  rd_ptr_d = rd_ptr_q + ONE;
        case ({push, pop})
            2'b10:   fill_d = fill_q + ONE;
            2'b01:   fill_d = fill_q - ONE;
            default: fill_d = fill_q;
        endcase
        case ({push && s_axis_tlast, pop && head_last})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            pkt_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            pkt_q    <= pkt_d;
            rdy_en_q <= 1'b1;
        end
    end

endmodule
